// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//   pll_state_t   - supervisor FSM states
//   DEF_*         - default timing constants (50 MHz reference clock)
//   cnt_width()   - width of the shared state counter
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_state_t;

    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_PLL_RST_CYCLES     = 64;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 500000;
    localparam int unsigned DEF_MAX_RETRIES        = 3;

    // The counter only ever reaches (limit - 1), so $clog2 of the largest
    // limit is enough; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flip-flop synchronizer for a single asynchronous bit.
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears all stages to 0
//   d_i  - asynchronous input
//   q_o  - d_i delayed by STAGES clk cycles
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset, qualifies the PLL lock and
// releases the downstream reset once lock has been stable. Lock loss or
// lock timeout re-resets the PLL, with a bounded number of timeout retries.
//   clk            - PLL reference clock
//   rst            - synchronous active-high reset
//   pll_lock_i     - PLL lock, asynchronous to clk
//   force_relock_i - single-cycle request to re-reset the PLL
//   pll_rst_o      - active-high PLL reset
//   sys_rst_o      - active-high reset for PLL-clocked logic
//   ready_o        - high only in RUN
//   fault_o        - high only in FAULT
//   retry_cnt_o    - timeout retries since last RUN entry / FAULT clear
//   loss_cnt_o     - lock-loss events seen in RUN, saturating at 255
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pll_lock_i,
    input  logic                             force_relock_i,
    output logic                             pll_rst_o,
    output logic                             sys_rst_o,
    output logic                             ready_o,
    output logic                             fault_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt_o,
    output logic [7:0]                       loss_cnt_o
);

    localparam int unsigned CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                                LOCK_TIMEOUT_CYCLES);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES+1);

    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that saw lock_s high is the first counted high
    // cycle, so STABLE itself only needs LOCK_STABLE_CYCLES-1 cycles.
    localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic lock_s;

    pll_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock_i),
        .q_o (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            RESET_PLL: begin
                if (force_relock_i) begin
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (force_relock_i) begin
                    state_d = RESET_PLL;
                end else if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = RESET_PLL;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            STABLE: begin
                if (force_relock_i) begin
                    state_d = RESET_PLL;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                // A lock loss coinciding with a relock request is still counted.
                if (!lock_s && (loss_q != 8'hFF)) begin
                    loss_d = loss_q + 8'd1;
                end
                if (force_relock_i || !lock_s) begin
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                cnt_d = cnt_q;
                if (force_relock_i) begin
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if (state_d == RUN) begin
            retry_d = '0;
        end

        // Outputs are decoded from the next state so they line up with state_q.
        pll_rst_d = (state_d == RESET_PLL);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_rst_o   = sys_rst_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;
    assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed self-checking bench for pll_lock_supervisor
// with short timing parameters. Cycle n is the interval after the n-th rising
// edge following reset release; inputs are driven and outputs sampled 1 time
// unit after the rising edge.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       pll_lock_i;
    logic       force_relock_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       fault_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    int n_total;
    int n_pass;
    int cyc;
    int r;
    int exp_loss;

    pll_lock_supervisor #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_lock_i     (pll_lock_i),
        .force_relock_i (force_relock_i),
        .pll_rst_o      (pll_rst_o),
        .sys_rst_o      (sys_rst_o),
        .ready_o        (ready_o),
        .fault_o        (fault_o),
        .retry_cnt_o    (retry_cnt_o),
        .loss_cnt_o     (loss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pll_rst"}, pll_rst_o, 1);
        chk({tag, ".sys_rst"}, sys_rst_o, 1);
        chk({tag, ".ready"},   ready_o,   0);
        chk({tag, ".fault"},   fault_o,   0);
        chk({tag, ".retry"},   retry_cnt_o, 0);
        chk({tag, ".loss"},    loss_cnt_o,  0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        cyc     = 0;
        rst            = 1'b1;
        pll_lock_i     = 1'b0;
        force_relock_i = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");

        // Test 1: power-up lock
        rst = 1'b0;
        cyc = 0;
        chk("t1.pll_rst_c0", pll_rst_o, 1);
        run_to(3);  chk("t1.pll_rst_c3", pll_rst_o, 1);
        run_to(4);  chk("t1.pll_rst_c4", pll_rst_o, 0);
                    chk("t1.sys_rst_c4", sys_rst_o, 1);
        run_to(10); pll_lock_i = 1'b1;
        run_to(19); chk("t1.sys_rst_c19", sys_rst_o, 1);
                    chk("t1.ready_c19", ready_o, 0);
        run_to(20); chk("t1.sys_rst_c20", sys_rst_o, 0);
                    chk("t1.ready_c20", ready_o, 1);
                    chk("t1.retry_c20", retry_cnt_o, 0);

        // Test 2: relock from RUN, then a one-cycle glitch at STABLE count 5
        run_to(25); force_relock_i = 1'b1;
        run_to(26); force_relock_i = 1'b0;
                    chk("t2.ready_c26", ready_o, 0);
                    chk("t2.pll_rst_c26", pll_rst_o, 1);
                    chk("t2.loss_c26", loss_cnt_o, 0);
        run_to(29); chk("t2.pll_rst_c29", pll_rst_o, 1);
        run_to(30); chk("t2.pll_rst_c30", pll_rst_o, 0);
        run_to(34); pll_lock_i = 1'b0;
        run_to(35); pll_lock_i = 1'b1;
        run_to(38); chk("t2.ready_c38", ready_o, 0);
        run_to(44); chk("t2.ready_c44", ready_o, 0);
        run_to(45); chk("t2.ready_c45", ready_o, 1);
                    chk("t2.retry_c45", retry_cnt_o, 0);

        // Test 3: lock held low -> two retries then FAULT
        run_to(50); pll_lock_i = 1'b0; force_relock_i = 1'b1;
        run_to(51); force_relock_i = 1'b0;
        run_to(55); chk("t3.pll_rst_c55", pll_rst_o, 0);
        run_to(74); chk("t3.pll_rst_c74", pll_rst_o, 0);
                    chk("t3.retry_c74", retry_cnt_o, 0);
        run_to(75); chk("t3.pll_rst_c75", pll_rst_o, 1);
                    chk("t3.retry_c75", retry_cnt_o, 1);
        run_to(78); chk("t3.pll_rst_c78", pll_rst_o, 1);
        run_to(79); chk("t3.pll_rst_c79", pll_rst_o, 0);
        run_to(99); chk("t3.pll_rst_c99", pll_rst_o, 1);
                    chk("t3.retry_c99", retry_cnt_o, 2);
        run_to(102); chk("t3.pll_rst_c102", pll_rst_o, 1);
        run_to(103); chk("t3.pll_rst_c103", pll_rst_o, 0);
        run_to(122); chk("t3.fault_c122", fault_o, 0);
        run_to(123); chk("t3.fault_c123", fault_o, 1);
                     chk("t3.retry_c123", retry_cnt_o, 2);
                     chk("t3.sys_rst_c123", sys_rst_o, 1);
                     chk("t3.pll_rst_c123", pll_rst_o, 0);
        run_to(130); chk("t3.fault_c130", fault_o, 1);
                     chk("t3.ready_c130", ready_o, 0);

        // Test 4: leave FAULT with force_relock, then lock
        force_relock_i = 1'b1;
        run_to(131); force_relock_i = 1'b0; pll_lock_i = 1'b1;
                     chk("t4.fault_c131", fault_o, 0);
                     chk("t4.retry_c131", retry_cnt_o, 0);
                     chk("t4.pll_rst_c131", pll_rst_o, 1);
        run_to(134); chk("t4.pll_rst_c134", pll_rst_o, 1);
        run_to(135); chk("t4.pll_rst_c135", pll_rst_o, 0);
        run_to(142); chk("t4.ready_c142", ready_o, 0);
        run_to(143); chk("t4.ready_c143", ready_o, 1);
                     chk("t4.sys_rst_c143", sys_rst_o, 0);

        // Test 6a: force_relock in the same cycle lock_s falls in RUN
        run_to(145); pll_lock_i = 1'b0;
        run_to(147); force_relock_i = 1'b1;
                     chk("t6a.sys_rst_c147", sys_rst_o, 0);
        run_to(148); force_relock_i = 1'b0; pll_lock_i = 1'b1;
                     chk("t6a.sys_rst_c148", sys_rst_o, 1);
                     chk("t6a.pll_rst_c148", pll_rst_o, 1);
                     chk("t6a.loss_c148", loss_cnt_o, 1);
        run_to(151); chk("t6a.pll_rst_c151", pll_rst_o, 1);
        run_to(152); chk("t6a.pll_rst_c152", pll_rst_o, 0);
        run_to(160); chk("t6a.ready_c160", ready_o, 1);
                     chk("t6a.loss_c160", loss_cnt_o, 1);

        // Test 5: 300 lock losses in RUN, loss_cnt saturates at 255
        for (int k = 1; k <= 300; k++) begin
            r = 160 + 17 * (k - 1);
            exp_loss = (k + 1 > 255) ? 255 : k + 1;
            run_to(r + 2); pll_lock_i = 1'b0;
            if (k == 1) begin
                run_to(r + 4); chk("t5.sys_rst_pre", sys_rst_o, 0);
            end
            run_to(r + 5); pll_lock_i = 1'b1;
            chk("t5.sys_rst_post", sys_rst_o, 1);
            chk("t5.loss", loss_cnt_o, exp_loss);
            if (k == 1) begin
                chk("t5.pll_rst_post", pll_rst_o, 1);
                chk("t5.ready_post", ready_o, 0);
            end
            run_to(r + 17);
            chk("t5.ready_back", ready_o, 1);
        end
        chk("t5.loss_final", loss_cnt_o, 255);

        // Test 6b: rst asserted mid-STABLE
        run_to(5262); force_relock_i = 1'b1;
        run_to(5263); force_relock_i = 1'b0;
        run_to(5270); rst = 1'b1;
                      chk("t6b.pll_rst_c5270", pll_rst_o, 0);
                      chk("t6b.sys_rst_c5270", sys_rst_o, 1);
                      chk("t6b.ready_c5270", ready_o, 0);
                      chk("t6b.loss_c5270", loss_cnt_o, 255);
        run_to(5271); rst = 1'b0;
                      chk_reset_vals("t6b.rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer side of the system PLL's lock/reset interface. Runs on the PLL reference clock (50 MHz board clock) and drives the PLL reset input.
- Synchronizes and qualifies the PLL lock output and releases the downstream system reset only after lock has been stable.
- On lock loss or lock timeout, re-resets the PLL with bounded retries. Reports status to the rest of the design.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous pll_lock_i input (minimum 2).
- PLL_RST_CYCLES, 64, cycles pll_rst_o is held high per PLL reset pulse.
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release.
- LOCK_TIMEOUT_CYCLES, 500000, maximum cycles in WAIT_LOCK before a retry (10 ms at 50 MHz).
- MAX_RETRIES, 3, timeout-triggered PLL resets allowed before FAULT.

Ports:
- clk  in  1  PLL reference clock; all logic runs on this clock.
- rst  in  1  synchronous active-high reset.
- pll_lock_i  in  1  PLL lock, asynchronous to clk.
- force_relock_i  in  1  single-cycle request to re-reset the PLL.
- pll_rst_o  out  1  active-high PLL reset.
- sys_rst_o  out  1  active-high reset for PLL-clocked logic.
- ready_o  out  1  high only in RUN.
- fault_o  out  1  high only in FAULT.
- retry_cnt_o  out  $clog2(MAX_RETRIES+1)  timeout retries since last RUN/FAULT clear.
- loss_cnt_o  out  8  lock-loss events while in RUN; saturates at 255.

Behaviour:
- Interface rule (already decided): one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- All outputs are registered.
- Reset values:
  - State = RESET_PLL with counter 0.
  - pll_rst_o=1, sys_rst_o=1, ready_o=0, fault_o=0, retry_cnt_o=0, loss_cnt_o=0.
- lock_s is pll_lock_i delayed by SYNC_STAGES cycles. The FSM uses only lock_s.
- One shared counter cnt, wide enough for max(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES). It is cleared on every state change.
- RESET_PLL:
  - Outputs: pll_rst_o=1, sys_rst_o=1.
  - After exactly PLL_RST_CYCLES cycles in the state, go to WAIT_LOCK. pll_rst_o is low from the first WAIT_LOCK cycle.
  - force_relock_i here restarts cnt.
- WAIT_LOCK:
  - Outputs: pll_rst_o=0, sys_rst_o=1.
  - lock_s=1: go to STABLE.
  - Otherwise, when cnt reaches LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt < MAX_RETRIES: retry_cnt+1, go to RESET_PLL.
    - else: go to FAULT.
- STABLE:
  - Outputs: pll_rst_o=0, sys_rst_o=1.
  - cnt counts consecutive lock_s=1 cycles.
  - lock_s=0: return to WAIT_LOCK with a fresh timeout. retry_cnt is unchanged.
  - After LOCK_STABLE_CYCLES consecutive high cycles (including the entry cycle): go to RUN.
- RUN:
  - Outputs: sys_rst_o=0, ready_o=1. Both change in the same cycle, the first RUN cycle.
  - retry_cnt clears to 0 on entry.
  - lock_s=0: loss_cnt+1 (saturating at 255), go to RESET_PLL.
  - sys_rst_o reasserts in the cycle after lock_s falls.
- FAULT:
  - Outputs: fault_o=1, pll_rst_o=0, sys_rst_o=1. retry_cnt_o holds MAX_RETRIES.
  - Exit only via rst or force_relock_i.
- force_relock_i:
  - In WAIT_LOCK, STABLE or RUN: go to RESET_PLL; retry_cnt unchanged.
  - In FAULT: clear retry_cnt, go to RESET_PLL.
  - In RUN in the same cycle as lock_s=0: take the force path; loss_cnt still increments.
- rst mid-operation returns to the reset state regardless of current state. loss_cnt also clears.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT;
  - default timing constants;
  - a helper function for counter width.
- One sub-module: sync_ff, a parameterized SYNC_STAGES bit synchronizer for pll_lock_i, reset to 0.

Test Plan:
(Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=2, SYNC_STAGES=2.)
1. Release rst, raise pll_lock_i at cycle 10 and hold -> pll_rst_o high for cycles 0-3. sys_rst_o falls and ready_o rises exactly 2+8 cycles after lock rises. retry_cnt_o=0.
2. Lock glitch low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, STABLE count restarts, release delayed by a full 8 cycles after lock returns. retry_cnt_o unchanged.
3. pll_lock_i held low -> three WAIT_LOCK timeouts of 20 cycles. Two RESET_PLL pulses of 4 cycles each, retry_cnt_o counts 1, 2. fault_o=1 after the third timeout; sys_rst_o stays 1.
4. In FAULT, pulse force_relock_i, then lock high -> retry_cnt_o=0, 4-cycle pll_rst_o pulse, then RUN.
5. In RUN, drop lock -> loss_cnt_o=1, sys_rst_o=1 one cycle after lock_s falls, pll_rst_o pulse. Repeat 300 times -> loss_cnt_o saturates at 255.
6. force_relock_i in the same cycle lock_s falls in RUN -> single RESET_PLL entry, loss_cnt_o+1. Assert rst mid-STABLE -> all outputs return to their reset values in the next cycle.
